// File: rtl/mux_rr_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_arbiter_pkg : shared constants, FSM encoding and round-robin search
// Revision 1.0
// ---------------------------------------------------------------------------
package mux_rr_arbiter_pkg;

  localparam int NREQ = 4;
  localparam int SELW = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // Scan ptr, ptr+1, ... (mod NREQ); walking backwards lets the nearest hit win.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req,
                                    input logic [SELW-1:0] ptr);
    pick_t           res;
    logic [SELW-1:0] cand;
    res = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = ptr + SELW'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_rr_arbiter_mux_w.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_arbiter_mux_w : DW-wide 4:1 mux datapath
// Revision 1.0
// ---------------------------------------------------------------------------
module mux_rr_arbiter_mux_w
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [SELW-1:0] sel_i,
  input  logic [DW-1:0]   d0_i,
  input  logic [DW-1:0]   d1_i,
  input  logic [DW-1:0]   d2_i,
  input  logic [DW-1:0]   d3_i,
  output logic [DW-1:0]   y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mux_rr_arbiter : round-robin owner selection with hold limit over a 4:1 mux
// Revision 1.0
// ---------------------------------------------------------------------------
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic [DW-1:0]   d0_i,
  input  logic [DW-1:0]   d1_i,
  input  logic [DW-1:0]   d2_i,
  input  logic [DW-1:0]   d3_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [SELW-1:0] sel_o,
  output logic [DW-1:0]   y_o,
  output logic            valid_o,
  output logic [3:0]      busy_cnt_o
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [3:0]      busy_q, busy_d;
  logic            valid_q, valid_d;

  pick_t           w_any;
  pick_t           w_rot;
  logic            w_do_grant;
  logic [SELW-1:0] w_win;

  always_comb begin
    // Forced rotation must never pick the current owner again.
    w_any      = rr_pick(req_i, ptr_q);
    w_rot      = rr_pick(req_i & ~gnt_q, ptr_q);
    w_do_grant = 1'b0;
    w_win      = '0;
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any.found) begin
          w_do_grant = 1'b1;
          w_win      = w_any.idx;
        end
      end
      default: begin
        if (!req_i[sel_q]) begin
          if (w_any.found) begin
            w_do_grant = 1'b1;
            w_win      = w_any.idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = '0;
          end
        end else if (busy_q < HOLD_LIMIT) begin
          busy_d = busy_q + 4'd1;
        end else if (w_rot.found) begin
          w_do_grant = 1'b1;
          w_win      = w_rot.idx;
        end
      end
    endcase

    if (w_do_grant) begin
      state_d = ST_GRANT;
      gnt_d   = NREQ'(1) << w_win;
      sel_d   = w_win;
      busy_d  = 4'd1;
      ptr_d   = w_win + 2'd1;
    end
    valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  mux_rr_arbiter_mux_w #(.DW(DW)) u_mux (
    .sel_i (sel_q),
    .d0_i  (d0_i),
    .d1_i  (d1_i),
    .d2_i  (d2_i),
    .d3_i  (d3_i),
    .y_o   (y_o)
  );

  assign gnt_o      = gnt_q;
  assign sel_o      = sel_q;
  assign valid_o    = valid_q;
  assign busy_cnt_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mux_rr_arbiter : directed bench with a behavioural owner/queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] da [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic       db [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [3:0] gnt_a, gnt_b, busy_a, busy_b;
  logic [1:0] sel_a, sel_b;
  logic [7:0] y_a;
  logic       y_b, valid_a, valid_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.DW(8), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req_i(req),
    .d0_i(da[0]), .d1_i(da[1]), .d2_i(da[2]), .d3_i(da[3]),
    .gnt_o(gnt_a), .sel_o(sel_a), .y_o(y_a), .valid_o(valid_a), .busy_cnt_o(busy_a)
  );

  mux_rr_arbiter #(.DW(1), .MAX_HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .req_i(req),
    .d0_i(db[0]), .d1_i(db[1]), .d2_i(db[2]), .d3_i(db[3]),
    .gnt_o(gnt_b), .sel_o(sel_b), .y_o(y_b), .valid_o(valid_b), .busy_cnt_o(busy_b)
  );

  // Model: owner index (-1 = nobody), tenure length, next-priority index.
  int m_own [2] = '{-1, -1};
  int m_sel [2] = '{0, 0};
  int m_ptr [2] = '{0, 0};
  int m_hold[2] = '{0, 0};
  int m_lim [2] = '{4, 2};

  function automatic int first_from(logic [3:0] r, int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int o = m_own[k];
      automatic int h = m_hold[k];
      automatic int p = m_ptr[k];
      automatic int s = m_sel[k];
      automatic int w = -1;
      if (rst) begin
        o = -1; h = 0; p = 0; s = 0;
      end else if (o < 0 || !req[o]) begin
        w = first_from(req, p);
        if (w < 0) begin o = -1; h = 0; end
      end else if (h < m_lim[k]) begin
        h = h + 1;
      end else begin
        w = first_from(req & ~(4'b0001 << o), p);
      end
      if (!rst && w >= 0) begin
        o = w; s = w; h = 1; p = (w + 1) % 4;
      end
      m_own[k]  <= o;
      m_hold[k] <= h;
      m_ptr[k]  <= p;
      m_sel[k]  <= s;
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_gnt(int k);
    return (m_own[k] < 0) ? 0 : (1 << m_own[k]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.gnt", int'(gnt_a), exp_gnt(0));
      chk("a.sel", int'(sel_a), m_sel[0]);
      chk("a.valid", int'(valid_a), int'(m_own[0] >= 0));
      chk("a.busy", int'(busy_a), m_hold[0]);
      chk("a.y", int'(y_a), int'(da[m_sel[0]]));
      chk("b.gnt", int'(gnt_b), exp_gnt(1));
      chk("b.sel", int'(sel_b), m_sel[1]);
      chk("b.valid", int'(valid_b), int'(m_own[1] >= 0));
      chk("b.busy", int'(busy_b), m_hold[1]);
      chk("b.y", int'(y_b), int'(db[m_sel[1]]));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  int         rot_g [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int         rot_y [9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
  logic [3:0] vec   [12] = '{4'b0011, 4'b0011, 4'b0000, 4'b1010, 4'b1010, 4'b1010,
                             4'b1010, 4'b1010, 4'b0110, 4'b0001, 4'b1000, 4'b1111};

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) cyc();
    chk("idle.gnt", int'(gnt_a), 0);
    chk("idle.valid", int'(valid_a), 0);
    chk("idle.sel", int'(sel_a), 0);
    chk("idle.busy", int'(busy_a), 0);
    chk("idle.y", int'(y_a), 8'hA0);

    // Glitch between edges is ignored.
    @(posedge clk);
    #2 req = 4'b0100;
    #2 req = 4'b0000;
    cyc();
    cyc();
    chk("glitch.gnt", int'(gnt_a), 0);

    // Single requester 2 for three cycles.
    req = 4'b0100;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("solo.gnt", int'(gnt_a), 4'b0100);
      chk("solo.sel", int'(sel_a), 2);
      chk("solo.busy", int'(busy_a), i);
    end
    req = 4'b0000;
    cyc();
    chk("solo.drop", int'(gnt_a), 0);
    chk("solo.ysel", int'(y_a), 8'hC2);

    // Forced rotation with hold limit 2.
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rot.gnt", int'(gnt_b), 1 << rot_g[i]);
      chk("rot.y", int'(y_b), rot_y[i]);
    end

    // Owner 1 releases while 0 and 3 wait; ptr=2 so 3 wins without a bubble.
    do_reset();
    req = 4'b0010;
    cyc();
    chk("rel.own1", int'(gnt_a), 4'b0010);
    req = 4'b1001;
    cyc();
    chk("rel.gnt", int'(gnt_a), 4'b1000);
    chk("rel.valid", int'(valid_a), 1);
    req = 4'b0001;
    cyc();
    chk("rel.next", int'(gnt_a), 4'b0001);

    // Lone owner saturates at the hold limit.
    do_reset();
    req = 4'b0001;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("sat.gnt", int'(gnt_a), 4'b0001);
      chk("sat.busy", int'(busy_a), (i < 4) ? i : 4);
    end

    // Mid-tenure reset.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 3; i++) cyc();
    chk("mrst.pre", int'(busy_a), 3);
    rst = 1'b1;
    cyc();
    chk("mrst.gnt", int'(gnt_a), 0);
    chk("mrst.sel", int'(sel_a), 0);
    chk("mrst.valid", int'(valid_a), 0);
    rst = 1'b0;
    req = 4'b1111;
    cyc();
    chk("mrst.next", int'(gnt_a), 4'b0001);

    // Mixed patterns checked by the model only.
    foreach (vec[i]) begin
      req = vec[i];
      cyc();
    end
    req = 4'b0000;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin controller that shares one 4:1 mux datapath among four requesters.
- Samples four request lines, grants one owner, and drives the mux select so the owner's data reaches the shared output.
- Limits each owner's tenure with a hold limit.
- Sits in front of the existing 4:1 mux, which is reused as the datapath.

Parameters:
- DW, 1, data width of each requester input and of y.
- MAX_HOLD, 4, maximum consecutive granted cycles for one owner while another requester waits (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req  input  4  request lines; bit i = requester i
- d0  input  DW  requester 0 data
- d1  input  DW  requester 1 data
- d2  input  DW  requester 2 data
- d3  input  DW  requester 3 data
- gnt  output  4  one-hot grant, registered; 0 when idle
- sel  output  2  registered mux select = index of owner; holds last value when idle
- y  output  DW  shared mux output, combinational from sel and d0..d3
- valid  output  1  registered; high when gnt != 0
- busy_cnt  output  4  registered count of cycles the current owner has held the grant

Behaviour:
- Clocking:
  - All state changes on the rising clk edge.
  - rst is sampled on the edge only; there is no asynchronous path.
- Reset values:
  - gnt=0, sel=0, valid=0, busy_cnt=0, ptr=0, state=IDLE.
  - y follows d0 while sel=0.
- Internal state:
  - state {IDLE, GRANT}.
  - ptr[1:0], the next-priority index.
  - hold counter, exposed as busy_cnt.
- Priority search:
  - Start at ptr and scan ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The first set req bit wins.
- IDLE:
  - If req==0, stay in IDLE; gnt=0, valid=0, sel holds.
  - Otherwise go to GRANT on the next edge with the winner w: gnt=1<<w, sel=w, valid=1, busy_cnt=1, ptr=w+1 mod 4.
  - Latency: req seen before edge N gives gnt after edge N (1 cycle).
- GRANT, owner o:
  - Owner releases (req[o]=0):
    - If other requesters are pending, re-arbitrate and grant the winner on the same edge. There is no idle bubble.
    - If none are pending, return to IDLE: gnt=0, valid=0.
  - Owner keeps req[o]=1 and busy_cnt < MAX_HOLD: retain the grant; busy_cnt += 1.
  - Owner keeps req[o]=1, busy_cnt == MAX_HOLD, and another request is pending: force rotation to the winner, scanning from ptr (o+1). busy_cnt=1.
  - Owner keeps req[o]=1, busy_cnt == MAX_HOLD, and no other request is pending: retain the grant; busy_cnt saturates at MAX_HOLD.
- Boundary cases:
  - Release and hold expiry in the same cycle: treated as a release.
  - A requester is never granted twice in a row via forced rotation.
  - Wrap-around: ptr 3+1 gives 0.
  - Glitch pulses: a req pulse shorter than one cycle that is not present at an edge is ignored.
  - A request dropped in the cycle it would win is not granted.
- Mid-operation reset:
  - rst high at an edge overrides everything and all reset values apply after that edge.
  - An in-flight grant is dropped with no completion.
- Invariant: gnt is always zero or one-hot; sel == index(gnt) whenever valid=1.
- Width rule: y is exactly DW bits with no extension; busy_cnt is zero-extended to 4 bits.

Decomposition:
- Shared package/header:
  - NREQ=4, SELW=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Function or macro for the rotating priority search.
- Sub-module mux_w: parameterised-DW 4:1 mux, the existing mux datapath widened. It is instantiated once with sel as the select.
- Arbiter FSM, ptr and hold counter stay in the top block.

Test Plan:
- Reset, then req=0 for 5 cycles -> gnt=0, valid=0, sel=0, busy_cnt=0; y==d0.
- Only req=4'b0100, held 3 cycles then dropped -> gnt=4'b0100 after the first edge, sel=2, busy_cnt 1,2,3; gnt=0 one edge after the drop.
- MAX_HOLD=2, req=4'b1111 constant, d0..d3=0,1,0,1 (DW=1) -> grant order 0,0,1,1,2,2,3,3,0; y=0,0,1,1,0,0,1,1,0.
- Owner 1 drops req while req=4'b1001 pending, ptr=2 -> gnt moves to 4'b1000 on the same edge with valid staying high; next winner is 0.
- Owner 0 alone, held for 10 cycles with MAX_HOLD=4 -> grant retained throughout; busy_cnt saturates at 4.
- rst asserted for one edge while gnt=4'b0010 and busy_cnt=3 -> after that edge gnt=0, sel=0, valid=0, ptr=0; with req=4'b1111 the next grant goes to 0.
